// File: rtl/niosii_sys_key_pio_pkg.sv
// Shared constants and helpers for the Nios II input PIO.
// Register addresses and a width helper that never returns zero.
package niosII_sys_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd1;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd2;
  localparam logic [1:0] PIO_ADDR_POL  = 2'd3;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/niosii_sys_key_pio_if.sv
// Avalon-MM slave bus of the input PIO, plus its interrupt line.
// Handshake: a transfer happens in every cycle chipselect is high (write when
// write_n is low, otherwise read); there are no wait states, and readdata
// carries the addressed register one cycle after the request is sampled.
interface niosii_sys_key_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/niosii_sys_key_pio_debounce.sv
// One input bit: two-flop synchroniser followed by a stable-count debouncer.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
module niosII_sys_debounce
  import niosII_sys_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_BIT       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic r_sync1;
  logic r_sync2;
  logic r_stable;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= RESET_BIT;
      r_sync2 <= RESET_BIT;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk) begin
        if (reset) r_stable <= RESET_BIT;
        else       r_stable <= r_sync2;
      end
    end else begin : g_count
      localparam int CW = clog2_min1(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] r_cnt;

      // Counter restarts on every agreeing sample, so it tops out at CNT_LAST.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt    <= '0;
          r_stable <= RESET_BIT;
        end else if (r_sync2 != r_stable) begin
          if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end
  endgenerate

  assign dout = r_stable;

endmodule

// File: rtl/niosii_sys_key_pio.sv
// Avalon-MM input PIO for keys/switches: debounced DATA, IRQ mask,
// sticky W1C edge capture with per-bit polarity, and a level irq.
module niosii_sys_key_pio
  import niosII_sys_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  niosii_sys_key_pio_if.slave bus
);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_pol;
  logic [31:0]      r_readdata;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_bit
      niosII_sys_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_BIT       (RESET_VALUE[g])
      ) u_db (
        .clk   (clk),
        .reset (reset),
        .din   (in_port[g]),
        .dout  (w_stable[g])
      );
    end
  endgenerate

  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_event;
  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_w1c;
  logic             w_unused_wd;

  assign w_rise      = w_stable & ~r_stable_d;
  assign w_fall      = ~w_stable & r_stable_d;
  assign w_event     = (r_pol & w_rise) | (~r_pol & w_fall);
  assign w_wr        = bus.chipselect & ~bus.write_n;
  assign w_wdata     = bus.writedata[WIDTH-1:0];
  assign w_w1c       = (w_wr && bus.address == PIO_ADDR_EDGE) ? w_wdata : '0;
  assign w_unused_wd = ^bus.writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable_d <= RESET_VALUE;
      r_mask     <= '0;
      r_cap      <= '0;
      r_pol      <= '0;
    end else begin
      r_stable_d <= w_stable;
      // A new event outranks a same-cycle clear of that bit.
      r_cap      <= (r_cap & ~w_w1c) | w_event;
      if (w_wr && bus.address == PIO_ADDR_MASK) r_mask <= w_wdata;
      if (w_wr && bus.address == PIO_ADDR_POL)  r_pol  <= w_wdata;
    end
  end

  logic [31:0] w_rdmux;

  always_comb begin
    w_rdmux = '0;
    case (bus.address)
      PIO_ADDR_DATA: w_rdmux[WIDTH-1:0] = w_stable;
      PIO_ADDR_MASK: w_rdmux[WIDTH-1:0] = r_mask;
      PIO_ADDR_EDGE: w_rdmux[WIDTH-1:0] = r_cap;
      PIO_ADDR_POL:  w_rdmux[WIDTH-1:0] = r_pol;
      default:       w_rdmux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_readdata <= '0;
    else       r_readdata <= bus.chipselect ? w_rdmux : 32'd0;
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = |(r_cap & r_mask);

endmodule
